// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit feeding decode.
//
// Holds the fetch PC and issues single-word requests to instruction memory
// with at most one request outstanding. Returned words are tagged with their
// PC and queued in a small FIFO that drives decode over valid/ready. A
// redirect flushes the queue and restarts fetch at a new address. A response
// that belongs to a request issued before the redirect is dropped.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target queues one fault
//               entry {redirect_pc, NOP, fault=1} and stops fetching until
//               the next redirect.
//   undefined : redirect_pc[1:0] is ignored and out_fault is tied to 0.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   redirect_valid/pc   flush and restart fetch at redirect_pc
//   imem_req_*          request channel (valid/ready, word address)
//   imem_rsp_*          in-order response channel (no backpressure)
//   out_valid/ready     head of fetch queue toward decode
//   out_pc/inst/fault   head entry payload (registered)
// ----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DROP  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [31:0]        tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               issue_en_q, issue_en_d;
  logic               fault_pend_q, fault_pend_d;
  logic               fault_done_q, fault_done_d;
  logic [31:0]        fault_pc_q, fault_pc_d;
  entry_t             head_q, head_d;
  logic               out_valid_q, out_valid_d;
  entry_t             fifo_q [DEPTH];

  logic               req_valid_c;
  logic               rsp_take_c;
  logic               fault_push_c;
  logic               accept_c;
  logic               push_c;
  logic               pop_c;
  logic               misalign_c;
  logic               room_c;
  logic [CNT_W:0]     occ_c;
  entry_t             push_entry_c;

  // Misaligned redirect detection (feature-gated).
`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign out_fault  = head_q.fault;
`else
  assign misalign_c = 1'b0;
  assign out_fault  = 1'b0;
  logic unused_fault_c;
  assign unused_fault_c = head_q.fault;
`endif

  // Occupancy counts the outstanding request so a full queue is never pushed.
  assign occ_c  = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
  assign room_c = occ_c < (CNT_W+1)'(DEPTH);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (inflight_q && !imem_rsp_valid) begin
        state_d = ST_DROP;
      end else if (misalign_c) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN:   state_d = ST_RUN;
        ST_DROP:  if (imem_rsp_valid) state_d = fault_pend_q ? ST_FAULT : ST_RUN;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs. A new request may chain on the response of the previous one.
  always_comb begin
    req_valid_c  = 1'b0;
    rsp_take_c   = 1'b0;
    fault_push_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        req_valid_c = issue_en_q && !redirect_valid && room_c &&
                      (!inflight_q || imem_rsp_valid);
        rsp_take_c  = inflight_q && imem_rsp_valid && !redirect_valid;
      end
      ST_FAULT: begin
        fault_push_c = !fault_done_q && !redirect_valid;
      end
      default: begin
        req_valid_c = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = fpc_q;
  assign accept_c       = req_valid_c && imem_req_ready;
  assign push_c         = rsp_take_c || fault_push_c;
  assign pop_c          = out_valid_q && out_ready;

  // Entry written into the queue this cycle.
  always_comb begin
    push_entry_c = '0;
    if (fault_push_c) begin
      push_entry_c.pc    = fault_pc_q;
      push_entry_c.inst  = NOP_INST;
      push_entry_c.fault = 1'b1;
    end else begin
      push_entry_c.pc    = tag_q;
      push_entry_c.inst  = imem_rsp_data;
      push_entry_c.fault = 1'b0;
    end
  end

  // Fetch PC, outstanding-request tracking and fault bookkeeping.
  always_comb begin
    fpc_d        = fpc_q;
    tag_d        = tag_q;
    inflight_d   = inflight_q;
    issue_en_d   = 1'b1;
    fault_pend_d = fault_pend_q;
    fault_done_d = fault_done_q;
    fault_pc_d   = fault_pc_q;
    if (redirect_valid) begin
      fpc_d        = {redirect_pc[31:2], 2'b00};
      inflight_d   = inflight_q && !imem_rsp_valid;
      fault_pend_d = misalign_c;
      fault_done_d = 1'b0;
      fault_pc_d   = redirect_pc;
    end else begin
      if (accept_c) begin
        fpc_d      = fpc_q + 32'd4;
        tag_d      = fpc_q;
        inflight_d = 1'b1;
      end else if (imem_rsp_valid) begin
        inflight_d = 1'b0;
      end
      if (fault_push_c) begin
        fault_done_d = 1'b1;
      end
    end
  end

  // Queue pointers, count and registered head. The head register takes the
  // incoming entry directly when it lands in the slot that becomes the head.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
    out_valid_d = (count_d != '0);
    if (out_valid_d) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_entry_c;
      end else begin
        head_d = fifo_q[rd_ptr_d];
      end
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q        <= RESET_PC;
      tag_q        <= '0;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      issue_en_q   <= 1'b0;
      fault_pend_q <= 1'b0;
      fault_done_q <= 1'b0;
      fault_pc_q   <= '0;
      head_q       <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      fpc_q        <= fpc_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_en_q   <= issue_en_d;
      fault_pend_q <= fault_pend_d;
      fault_done_q <= fault_done_d;
      fault_pc_q   <= fault_pc_d;
      head_q       <= head_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_c) begin
      fifo_q[wr_ptr_q] <= push_entry_c;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = head_q.pc;
  assign out_inst  = head_q.inst;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int checks = 0;
  int failures = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // ---------------- memory: in-order, fixed latency ----------------
  int          cyc = 0;
  int          mem_lat = 1;
  logic        mem_ready;
  logic        mem_rsp_v;
  logic [31:0] mem_rsp_d;
  logic        spur_rsp;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  assign imem_req_ready = mem_ready;
  assign imem_rsp_valid = mem_rsp_v | spur_rsp;
  assign imem_rsp_data  = spur_rsp ? 32'hDEAD_BEEF : mem_rsp_d;

  always @(negedge clk) begin
    if (!rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + mem_lat);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      mem_rsp_v = 1'b1;
      mem_rsp_d = mq_addr[0] ^ 32'hFFFF_FFFF;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rsp_v = 1'b0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ment_t;

  ment_t       m_fifo[$];
  logic [31:0] o_addr[$];
  bit          o_stale[$];
  logic [31:0] m_fpc;
  bit          m_started;
  bit          m_fmode;
  bit          m_fpushed;
  logic [31:0] m_fault_pc;

  always @(negedge clk) begin
    bit    exp_rv;
    bit    pop;
    ment_t e;
    if (!rst) begin
      cmp("rst_req_valid", 32'(imem_req_valid), 32'd0);
      cmp("rst_out_valid", 32'(out_valid), 32'd0);
      cmp("rst_out_pc", out_pc, 32'd0);
      cmp("rst_out_inst", out_inst, 32'd0);
      cmp("rst_out_fault", 32'(out_fault), 32'd0);
      m_fifo.delete();
      o_addr.delete();
      o_stale.delete();
      m_fpc     = RESET_PC;
      m_started = 1'b0;
      m_fmode   = 1'b0;
      m_fpushed = 1'b0;
    end else begin
      exp_rv = m_started && !redirect_valid && !m_fmode &&
               (m_fifo.size() + o_addr.size() < DEPTH) &&
               (o_addr.size() == 0 || (imem_rsp_valid && !o_stale[0]));
      cmp("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) cmp("req_addr", imem_req_addr, m_fpc);
      cmp("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        cmp("out_pc", out_pc, m_fifo[0].pc);
        cmp("out_inst", out_inst, m_fifo[0].inst);
        cmp("out_fault", 32'(out_fault), 32'(m_fifo[0].fault));
      end
      m_started = 1'b1;
      if (redirect_valid) begin
        m_fifo.delete();
        if (imem_rsp_valid && o_addr.size() != 0) begin
          void'(o_addr.pop_front());
          void'(o_stale.pop_front());
        end
        foreach (o_stale[i]) o_stale[i] = 1'b1;
        m_fpc     = {redirect_pc[31:2], 2'b00};
        m_fmode   = 1'b0;
        m_fpushed = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        m_fmode    = (redirect_pc[1:0] != 2'b00);
        m_fault_pc = redirect_pc;
`endif
      end else begin
        pop = out_ready && (m_fifo.size() != 0);
        if (pop) void'(m_fifo.pop_front());
        if (m_fmode && !m_fpushed && o_addr.size() == 0) begin
          e.pc = m_fault_pc; e.inst = 32'h0000_0013; e.fault = 1'b1;
          m_fifo.push_back(e);
          m_fpushed = 1'b1;
        end
        if (imem_rsp_valid && o_addr.size() != 0) begin
          e.pc = o_addr.pop_front();
          e.inst = ~e.pc;
          e.fault = 1'b0;
          if (!o_stale.pop_front()) m_fifo.push_back(e);
        end
        if (exp_rv && imem_req_ready) begin
          o_addr.push_back(m_fpc);
          o_stale.push_back(1'b0);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    cmp(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b1; mem_ready = 1'b1; spur_rsp = 1'b0;
    step(); step();
    cmp("reset_out_pc", out_pc, 32'h0);
    cmp("reset_req_valid", 32'(imem_req_valid), 32'd0);

    // Streaming with 1-cycle memory and decode always ready.
    rst = 1'b1;
    step();
    cmp("first_req_valid", 32'(imem_req_valid), 32'd1);
    cmp("first_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    cmp("second_req_addr", imem_req_addr, 32'h8000_0004);
    step();
    cmp("first_out_pc", out_pc, 32'h8000_0000);
    cmp("first_out_inst", out_inst, 32'h7FFF_FFFF);
    step();
    cmp("second_out_pc", out_pc, 32'h8000_0004);
    repeat (10) step();

    // Request held across random ready stalls.
    for (int i = 0; i < 24; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    mem_ready = 1'b1;
    repeat (4) step();

    // Backpressure: queue fills to DEPTH, then drains in order.
    out_ready = 1'b0;
    do_redirect(32'h8000_0000);
    repeat (15) step();
    cmp("full_req_valid", 32'(imem_req_valid), 32'd0);
    cmp("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cmp("drain0", out_pc, 32'h8000_0000);
    step(); cmp("drain1", out_pc, 32'h8000_0004);
    step(); cmp("drain2", out_pc, 32'h8000_0008);
    step(); cmp("drain3", out_pc, 32'h8000_000C);
    repeat (6) step();

    // Redirect while a 3-cycle request to 80000008 is outstanding.
    mem_lat = 3;
    do_redirect(32'h8000_0000);
    n = 0;
    while (!(imem_req_valid && imem_req_ready && imem_req_addr == 32'h8000_0008) && n < 60) begin
      step(); n++;
    end
    cmp("wait_req_8", 32'(imem_req_addr == 32'h8000_0008), 32'd1);
    step();
    do_redirect(32'h8000_1000);
    wait_out("redir_wait");
    cmp("redir_pc", out_pc, 32'h8000_1000);
    cmp("redir_inst", out_inst, 32'h7FFF_EFFF);
    repeat (8) step();

    // Redirect coinciding with a response and a ready request.
    mem_lat = 1;
    repeat (4) step();
    n = 0;
    while (!(imem_rsp_valid && imem_req_valid && imem_req_ready) && n < 60) begin
      step(); n++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    #1;
    cmp("redir_forces_req_low", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    wait_out("same_cycle_wait");
    cmp("same_cycle_pc", out_pc, 32'h8000_2000);
    repeat (6) step();

    // Back-to-back redirects while a 4-cycle request is outstanding.
    mem_lat = 4;
    n = 0;
    while (!(imem_req_valid && imem_req_ready) && n < 60) begin
      step(); n++;
    end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
    step();
    redirect_pc = 32'h8000_3100;
    step();
    redirect_valid = 1'b0;
    wait_out("drop_redir_wait");
    cmp("drop_redir_pc", out_pc, 32'h8000_3100);
    repeat (10) step();

    // Asynchronous reset with count=3 and a request outstanding.
    mem_lat = 2;
    out_ready = 1'b0;
    do_redirect(32'h8000_0000);
    n = 0;
    while (!(m_fifo.size() == 3 && o_addr.size() == 1) && n < 60) begin
      step(); n++;
    end
    cmp("reach_cnt3_inflight", 32'(m_fifo.size() == 3 && o_addr.size() == 1), 32'd1);
    rst = 1'b0;
    #1;
    cmp("async_rst_out_valid", 32'(out_valid), 32'd0);
    cmp("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    spur_rsp = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    cmp("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    cmp("post_rst_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    spur_rsp = 1'b0;
    wait_out("post_rst_wait");
    cmp("post_rst_pc", out_pc, 32'h8000_0000);
    cmp("post_rst_inst", out_inst, 32'h7FFF_FFFF);
    repeat (6) step();

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned redirect yields a single fault entry and halts fetch.
    mem_lat = 1;
    do_redirect(32'h8000_0102);
    wait_out("fault_wait");
    cmp("fault_pc", out_pc, 32'h8000_0102);
    cmp("fault_inst", out_inst, 32'h0000_0013);
    cmp("fault_flag", 32'(out_fault), 32'd1);
    repeat (6) step();
    cmp("fault_no_req", 32'(imem_req_valid), 32'd0);
    cmp("fault_single", 32'(out_valid), 32'd0);
    do_redirect(32'h8000_0200);
    wait_out("fault_exit_wait");
    cmp("fault_exit_pc", out_pc, 32'h8000_0200);
    cmp("fault_exit_flag", 32'(out_fault), 32'd0);
`else
    // Low redirect bits are ignored.
    mem_lat = 1;
    do_redirect(32'h8000_0306);
    wait_out("align_wait");
    cmp("align_pc", out_pc, 32'h8000_0304);
    cmp("align_fault", 32'(out_fault), 32'd0);
`endif
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit placed directly upstream of instruction decode. Holds the fetch PC and issues one-word requests to instruction memory over a valid/ready request channel with an in-order response channel. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready interface. A redirect input, driven by the branch/jump next-PC logic, flushes the fetch stream and restarts it at a new address.

## Interface
- `RESET_PC`, 32'h80000000: fetch address after reset.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word address, bits [1:0] always 0.
- `imem_rsp_valid`  in  1  response data valid, in request order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `out_valid`  out  1  FIFO head valid toward decode.
- `out_ready`  in  1  decode consumes the head.
- `out_pc`  out  32  PC of head entry.
- `out_inst`  out  32  instruction of head entry.
- `out_fault`  out  1  head entry is a misaligned-fetch fault (see Configuration).

## Operation
- State: `fpc` (32), FIFO of {pc, inst, fault}, `count` (0..DEPTH), `inflight` (0/1, at most one outstanding request), FSM {RUN, DROP, FAULT}.
- Request is issued in RUN when `(count + inflight) < DEPTH`, on registered values with no same-cycle pop bypass, and either `inflight == 0` or `imem_rsp_valid` is high this cycle. `imem_req_addr = fpc`. `imem_req_valid` is held high until it is accepted. On acceptance, `fpc <= fpc + 4` (mod 2^32), and the request address is captured for tagging the response.
- Response in RUN: push {captured addr, `imem_rsp_data`, 0}. `inflight` is cleared unless a new request is accepted in the same cycle.
- Pop: when `out_valid && out_ready`. Push and pop can happen in the same cycle; `count` is then unchanged. Pointers wrap modulo DEPTH.
- Redirect has priority over all other events in the cycle:
  - `imem_req_valid` is forced low combinationally.
  - The FIFO is flushed and `fpc <= {redirect_pc[31:2], 2'b00}`.
  - A response arriving in the same cycle is discarded.
  - If a request is still outstanding after this cycle, the FSM goes to DROP; otherwise it goes to RUN.
- DROP: no requests are issued. The next response is discarded, then the FSM goes to RUN. A further redirect while in DROP updates `fpc` and stays in DROP.
- No combinational path exists from `out_ready` to `imem_req_valid`.

## Timing
- Reset values: `fpc = RESET_PC`, `count = 0`, `inflight = 0`, FSM = RUN, `imem_req_valid = 0`, `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `out_fault = 0`.
- First request: `imem_req_valid` rises in the first cycle after reset release.
- Latency: a response received in cycle N becomes visible on `out_*` in cycle N+1.
- `out_valid = (count != 0)`. Head outputs come from registered FIFO storage.
- Throughput: with 1-cycle memory latency and decode always ready, one instruction per cycle is sustained. With `count + inflight == DEPTH`, issue stalls until a pop.
- Full: no push can occur, because the occupancy rule prevents over-issue. Empty: `out_valid = 0` and `out_pc`/`out_inst` hold their last values.
- Reset asserted mid-transfer: all state clears immediately, and any later response is ignored until a new request is accepted.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0] != 0` flushes, then enters FAULT (via DROP if a request is outstanding). In FAULT:
  - One entry {redirect_pc, 32'h00000013, 1} is pushed.
  - No further requests are issued.
  - The block leaves FAULT only on the next redirect.
- `IFU_MISALIGN_CHECK_EN` undefined: `redirect_pc[1:0]` is ignored, FAULT is unreachable, and `out_fault` is tied to 0.

## Test plan
- Reset release, memory with 1-cycle latency returning addr^32'hFFFFFFFF, `out_ready = 1` → requests go to 80000000, 80000004, …; `out_pc`/`out_inst` match one per cycle after a 2-cycle startup.
- `out_ready = 0` held → exactly DEPTH=4 entries are accepted, then `imem_req_valid` stays 0. Releasing `out_ready` drains 80000000..8000000C in order.
- Redirect to 80001000 while a request to 80000008 is outstanding with 3-cycle latency → that response is discarded, the next `out_pc` is 80001000, and no stale entry appears.
- Redirect in the same cycle as `imem_rsp_valid`, and also in the same cycle as `imem_req_ready` → the response is dropped and no request is accepted. Fetch resumes at the target.
- Assert `rst` low while `inflight = 1` and `count = 3` → `out_valid = 0` and `imem_req_valid = 0` immediately. After release, the first request is to 80000000.
- With `IFU_MISALIGN_CHECK_EN`: redirect to 80000102 → a single entry with `out_fault = 1`, `out_pc = 80000102` and no requests. A later redirect to 80000200 resumes normal fetch.
